multicycle_carry_adder: RTL and testbench
=========================================

Name: multicycle_carry_adder

Overview:
Parametrised, chunk-serial successor to the 64-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock. A registered carry links each chunk to the next, so the critical path stays at CHUNK bits. Sits in the datapath behind a valid/ready handshake on both sides and holds its result until the consumer accepts it.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 16, bits added per cycle; 1 <= CHUNK <= WIDTH.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  synchronous active-low reset.
IN_VALID  input  1  operands valid.
IN_READY  output  1  block can accept operands.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
CIN  input  1  carry-in (borrow-in when SUB=1).
SUB  input  1  0: A+B+CIN; 1: A-B-CIN.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  consumer accepts result.
SUM  output  WIDTH  result, modulo 2^WIDTH.
COUT  output  1  raw carry out of MSB; in SUB mode 1 = no borrow.
OVF  output  1  two's-complement overflow.

Behaviour:
- One clock; reset is synchronous and active-low.
- NCHUNK = WIDTH/CHUNK.
- Reset (RST_N=0 at a CLK edge):
  - state=IDLE, chunk counter=0, carry reg=0.
  - SUM=0, COUT=0, OVF=0, OUT_VALID=0.
  - IN_READY=1 from the first cycle after reset.
  - Reset overrides every other input, including mid-RUN or in HOLD; an in-flight result is discarded and no OUT_VALID is produced.
- FSM states: IDLE, RUN, HOLD.
  - IN_READY = (state==IDLE); OUT_VALID = (state==HOLD); both are decoded from registered state only.
- IDLE: on IN_VALID=1:
  - Latch A into opa.
  - Latch opb = SUB ? ~B : B.
  - carry = SUB ? ~CIN : CIN.
  - counter=0; go to RUN.
  - IN_VALID=0 stays in IDLE.
- RUN, each cycle:
  - Add chunk k=counter: {c_out, s} = opa[k*CHUNK +: CHUNK] + opb[k*CHUNK +: CHUNK] + carry.
  - Write s into SUM[k*CHUNK +: CHUNK]; carry <= c_out; counter++.
  - When k==NCHUNK-1: COUT <= c_out, OVF <= c_out XOR (carry into MSB of that chunk); go to HOLD.
- Latency: OUT_VALID rises exactly NCHUNK cycles after the accepting edge. For CHUNK=WIDTH that is 1 cycle.
- HOLD:
  - SUM/COUT/OVF stable. IN_VALID is ignored (IN_READY=0).
  - On OUT_READY=1, go to IDLE; outputs retain their last values.
  - Throughput: one operation per NCHUNK+2 cycles with OUT_READY tied high.
- SUM chunks not yet written during RUN hold their previous values. Only the HOLD contents are architecturally defined.
- A, B, CIN and SUB are sampled only on the accepting edge; later changes have no effect.
- OUT_READY outside HOLD is ignored.
- Counter width: max(1, clog2(NCHUNK)); it never exceeds NCHUNK-1.

Decomposition:
- Package multicycle_adder_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, HOLD=2'd2).
  - function computing NCHUNK and counter width.
  - elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module carry_chunk_adder:
  - combinational CHUNK-bit adder built from the existing single-bit adder cells.
  - outputs S[CHUNK-1:0], COUT, and C_MSB (carry into bit CHUNK-1) for overflow.
  - instantiated once and time-multiplexed over chunks.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles, release.
  - Required: SUM=0, COUT=0, OVF=0, OUT_VALID=0 during reset; IN_READY=1 on the first cycle after release.
- Carry across chunks (WIDTH=64, CHUNK=16): A=64'hFFFF_FFFF_FFFF_FFFF, B=1, CIN=0, SUB=0.
  - Required: OUT_VALID 4 cycles after accept; SUM=0, COUT=1, OVF=0.
- Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, CIN=0, SUB=0.
  - Required: SUM=64'h8000_0000_0000_0000, COUT=0, OVF=1.
- Subtract with borrow: A=5, B=7, CIN=0, SUB=1.
  - Required: SUM=64'hFFFF_FFFF_FFFF_FFFE, COUT=0, OVF=0.
  - Repeat with A=7, B=5, CIN=1: SUM=1, COUT=1.
- Backpressure: complete an operation, hold OUT_READY=0 for 10 cycles while toggling IN_VALID/A/B.
  - Required: SUM/COUT/OVF unchanged and IN_READY=0 throughout.
  - On OUT_READY=1: IDLE next cycle, IN_READY=1.
- Reset mid-RUN: assert RST_N=0 after 2 RUN cycles.
  - Required: next cycle IDLE, outputs 0, no OUT_VALID pulse.
  - A following op A=3, B=4 gives SUM=7.
  - Rerun the carry scenario with CHUNK=64 (1-cycle latency) and CHUNK=1 (64-cycle latency).

Source files
------------

// File: rtl/multicycle_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_adder_pkg : shared types and sizing helpers for the chunk adder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter needs at least one bit even when the whole word fits in one chunk.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_carry_adder_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | carry_chunk_adder : combinational CHUNK-bit ripple adder from 1-bit cells  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);
  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (CIN & (A ^ B));
endmodule

module carry_chunk_adder
  import multicycle_adder_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             CIN,
  output logic [CHUNK-1:0] S,
  output logic             COUT,
  output logic             C_MSB
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = CIN;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder_cell u_fa (
      .A    (A[i]),
      .B    (B[i]),
      .CIN  (w_c[i]),
      .S    (S[i]),
      .COUT (w_c[i+1])
    );
  end

  // Carry into the top bit is kept so the caller can form signed overflow.
  assign COUT  = w_c[CHUNK];
  assign C_MSB = w_c[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/multicycle_carry_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_carry_adder : chunk-serial add/sub with valid/ready handshakes  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module multicycle_carry_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);
  localparam int c_NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int c_CNT_W  = cnt_width(c_NCHUNK);
  localparam int c_IDX_W  = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NCHUNK - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_CHUNK_SZ = c_IDX_W'(CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("multicycle_carry_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [c_IDX_W-1:0] w_base;
  logic [CHUNK-1:0]   w_s;
  logic               w_co;
  logic               w_cmsb;

  assign w_base = c_IDX_W'(r_cnt) * c_CHUNK_SZ;

  // One adder slice, time-multiplexed across chunks by the counter.
  carry_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .A     (r_opa[w_base +: CHUNK]),
    .B     (r_opb[w_base +: CHUNK]),
    .CIN   (r_carry),
    .S     (w_s),
    .COUT  (w_co),
    .C_MSB (w_cmsb)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            // Subtraction is A + ~B + ~borrow.
            r_opa   <= A;
            r_opb   <= SUB ? ~B : B;
            r_carry <= SUB ? ~CIN : CIN;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_s;
          r_carry                <= w_co;
          if (r_cnt == c_CNT_LAST) begin
            r_cout  <= w_co;
            r_ovf   <= w_co ^ w_cmsb;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = (r_state == HOLD);
  assign SUM       = r_sum;
  assign COUT      = r_cout;
  assign OVF       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_carry_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_carry_adder : three chunk configurations against a model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_multicycle_carry_adder;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic            cin;
  logic            sub;
  logic [63:0]     a;
  logic [63:0]     b;
  logic [ND-1:0]   in_ready;
  logic [ND-1:0]   out_valid;
  logic [ND-1:0]   cout;
  logic [ND-1:0]   ovf;
  logic [63:0]     sum [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_carry_adder #(.WIDTH(64), .CHUNK(16)) u_dut16 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready[0]),
    .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready), .SUM(sum[0]), .COUT(cout[0]), .OVF(ovf[0]));

  multicycle_carry_adder #(.WIDTH(64), .CHUNK(64)) u_dut64 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready[1]),
    .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready), .SUM(sum[1]), .COUT(cout[1]), .OVF(ovf[1]));

  multicycle_carry_adder #(.WIDTH(64), .CHUNK(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready[2]),
    .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid[2]),
    .OUT_READY(out_ready), .SUM(sum[2]), .COUT(cout[2]), .OVF(ovf[2]));

  function automatic int nch_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  // Reference: exact unsigned/signed arithmetic on widened operands.
  function automatic void ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                    input logic rc, input logic rs,
                                    output logic [63:0] es, output logic ec,
                                    output logic eo);
    logic [64:0] u;
    logic [65:0] t;
    logic [65:0] sa;
    logic [65:0] sb;
    sa = {{2{ra[63]}}, ra};
    sb = {{2{rb[63]}}, rb};
    if (!rs) begin
      u  = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      es = u[63:0];
      ec = u[64];
      t  = sa + sb + 66'(rc);
    end else begin
      es = ra - rb - 64'(rc);
      ec = ({1'b0, ra} >= ({1'b0, rb} + 65'(rc)));
      t  = sa - sb - 66'(rc);
    end
    eo = (t[65:63] != 3'b000) && (t[65:63] != 3'b111);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag, input logic [63:0] es,
                            input logic ec, input logic eo);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s d%0d sum", tag, d), sum[d], es);
      check($sformatf("%s d%0d cout", tag, d), 64'(cout[d]), 64'(ec));
      check($sformatf("%s d%0d ovf", tag, d), 64'(ovf[d]), 64'(eo));
    end
  endtask

  task automatic do_op(input logic [63:0] ra, input logic [63:0] rb,
                       input logic rc, input logic rs, input string tag, input bit bp);
    logic [63:0] es;
    logic        ec;
    logic        eo;
    int          lat [ND];
    ref_model(ra, rb, rc, rs, es, ec, eo);
    check({tag, " ready_before"}, 64'(in_ready), 64'(3'b111));
    a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) lat[d] = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      // Inputs after the accepting edge must have no effect.
      in_valid = 1'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++)
        if (out_valid[d] && lat[d] == 0) lat[d] = cyc;
      if (&out_valid) break;
    end
    for (int d = 0; d < ND; d++)
      check($sformatf("%s d%0d latency", tag, d), 64'(lat[d]), 64'(nch_of(d)));
    check_hold(tag, es, ec, eo);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'($urandom);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        @(posedge clk); #1;
        check_hold({tag, " bp"}, es, ec, eo);
        check({tag, " bp in_ready"}, 64'(in_ready), 64'(0));
        check({tag, " bp out_valid"}, 64'(out_valid), 64'(3'b111));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " ready_after"}, 64'(in_ready), 64'(3'b111));
    check({tag, " valid_after"}, 64'(out_valid), 64'(0));
    check_hold({tag, " retained"}, es, ec, eo);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check_hold("reset", 64'd0, 1'b0, 1'b0);
      check("reset out_valid", 64'(out_valid), 64'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 64'(in_ready), 64'(3'b111));

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "carry", 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf", 1'b0);
    do_op(64'd5, 64'd7, 1'b0, 1'b1, "sub_borrow", 1'b1);
    do_op(64'd7, 64'd5, 1'b1, 1'b1, "sub_cin", 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, "sub_ovf", 1'b0);

    // Reset two cycles into an operation discards it.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_hold("midrun reset", 64'd0, 1'b0, 1'b0);
    check("midrun reset out_valid", 64'(out_valid), 64'(0));
    check("midrun reset in_ready", 64'(in_ready), 64'(3'b111));
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("after reset no out_valid", 64'(out_valid), 64'(0));
    end
    do_op(64'd3, 64'd4, 1'b0, 1'b0, "after_reset", 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 5 == 0) rb = ~ra;
      do_op(ra, rb, 1'($urandom), 1'($urandom), $sformatf("rand%0d", n), (n % 7) == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
